// File: rtl/regfile_scoreboard.sv
// Register file with two write ports, optional write-to-read bypass and a per-register busy scoreboard.
// Latency: reads are combinational (0 cycles); writes/reserves land at the next rising edge.
// Backpressure: none. Every write and reserve presented is accepted in the cycle it is presented.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset (clears all registers and busy bits)
//   ra1/ra2 -> rd1/rd2  combinational read data; busy1/busy2 give the scoreboard bit of the address
//   we0/wa0/wd0         write port 0 (ALU writeback)
//   we1/wa1/wd1         write port 1 (memory writeback), wins over port 0 on the same address
//   rsv_en/rsv_addr     mark a register busy for a pending multi-cycle write
module regfile_scoreboard #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$clog2(NREGS)-1:0] ra1,
    input  logic [$clog2(NREGS)-1:0] ra2,
    output logic [XLEN-1:0]          rd1,
    output logic [XLEN-1:0]          rd2,
    output logic                     busy1,
    output logic                     busy2,
    input  logic                     we0,
    input  logic [$clog2(NREGS)-1:0] wa0,
    input  logic [XLEN-1:0]          wd0,
    input  logic                     we1,
    input  logic [$clog2(NREGS)-1:0] wa1,
    input  logic [XLEN-1:0]          wd1,
    input  logic                     rsv_en,
    input  logic [$clog2(NREGS)-1:0] rsv_addr
);

    localparam int   AW = $clog2(NREGS);
    localparam logic ZR = (ZERO_REG != 0);
    localparam logic BP = (BYPASS != 0);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_busy;

    logic             w_we0_ok;
    logic             w_we1_ok;
    logic             w_rsv_ok;
    logic [NREGS-1:0] w_busy_nxt;

    // Writes and reserves aimed at a hardwired-zero register are dropped up front,
    // so register 0 never changes and never becomes busy.
    assign w_we0_ok = we0    && !(ZR && (wa0 == '0));
    assign w_we1_ok = we1    && !(ZR && (wa1 == '0));
    assign w_rsv_ok = rsv_en && !(ZR && (rsv_addr == '0));

    // A reserve in the same cycle as a write belongs to a newer producer,
    // so the set is applied after the clears.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_we0_ok) w_busy_nxt[wa0] = 1'b0;
        if (w_we1_ok) w_busy_nxt[wa1] = 1'b0;
        if (w_rsv_ok) w_busy_nxt[rsv_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            if (w_we0_ok) r_regs[wa0] <= wd0;
            // Port 1 is assigned last so it wins when both ports hit the same address.
            if (w_we1_ok) r_regs[wa1] <= wd1;
            r_busy <= w_busy_nxt;
        end
    end

    // Returns {busy, data} for one read address. Bypass ignores rst and ignores a
    // same-cycle reserve: a forwarded value is always reported as not busy.
    function automatic logic [XLEN:0] f_read(input logic [AW-1:0] ra);
        f_read = {r_busy[ra], r_regs[ra]};
        if (ZR && (ra == '0)) begin
            f_read = '0;
        end else if (BP && we1 && (wa1 == ra)) begin
            f_read = {1'b0, wd1};
        end else if (BP && we0 && (wa0 == ra)) begin
            f_read = {1'b0, wd0};
        end
    endfunction

    assign {busy1, rd1} = f_read(ra1);
    assign {busy2, rd2} = f_read(ra2);

endmodule
